fetch_stage_bp: RTL



---
 rtl/fetch_stage_bp.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage_bp.sv
// Instruction fetch stage with a direct-mapped BTB and per-entry saturating-counter
// direction predictor; drives imem and registers a fetch/decode latch.
module fetch_stage_bp #(
  parameter int unsigned     WORD_W      = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter int unsigned     CTR_BITS    = 2,
  parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] imemload,
  input  logic              freeze,
  input  logic              misprediction,
  input  logic [WORD_W-1:0] correct_pc,
  input  logic              halt,
  input  logic              update_btb,
  input  logic              branch_outcome,
  input  logic [WORD_W-1:0] update_pc,
  input  logic [WORD_W-1:0] branch_target,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instr,
  output logic              predicted_outcome,
  output logic [WORD_W-1:0] predicted_pc
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0]   f_q, f_d;
  logic [WORD_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic                pout_q, pout_d;
  logic [WORD_W-1:0]   ppc_q, ppc_d;

  logic                valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]    tag_q    [BTB_ENTRIES];
  logic [WORD_W-1:0]   target_q [BTB_ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]    f_idx, u_idx;
  logic [TAG_W-1:0]    f_tag, u_tag;
  logic                f_hit, u_hit;
  logic                pred_taken;
  logic [WORD_W-1:0]   pred_next;

  logic                upd_we;
  logic [WORD_W-1:0]   upd_target;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [1:0]          unused_upd_lsb;

  assign unused_upd_lsb = update_pc[1:0];

  // Lookup on the current fetch PC uses pre-update BTB contents.
  assign f_idx      = f_q[IDX_W+1:2];
  assign f_tag      = f_q[WORD_W-1:IDX_W+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken = f_hit && ctr_q[f_idx][CTR_BITS-1];
  assign pred_next  = pred_taken ? target_q[f_idx] : f_q + WORD_W'(4);

  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[WORD_W-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign imemaddr          = f_q;
  assign imemREN           = (state_q == S_RUN);
  assign pc                = pc_q;
  assign instr             = instr_q;
  assign predicted_outcome = pout_q;
  assign predicted_pc      = ppc_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Next PC / latch / halt selection; a redirect wins over halt and freeze.
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pout_d  = pout_q;
    ppc_d   = ppc_q;
    if (misprediction) begin
      f_d     = correct_pc;
      pc_d    = '0;
      instr_d = '0;
      pout_d  = 1'b0;
      ppc_d   = '0;
    end else if (state_q == S_HALT || halt) begin
      state_d = S_HALT;
    end else if (!freeze) begin
      f_d     = pred_next;
      pc_d    = f_q;
      instr_d = imemload;
      pout_d  = pred_taken;
      ppc_d   = pred_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      f_q     <= RESET_PC;
      pc_q    <= '0;
      instr_q <= '0;
      pout_q  <= 1'b0;
      ppc_q   <= '0;
    end else begin
      f_q     <= f_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pout_q  <= pout_d;
      ppc_q   <= ppc_d;
    end
  end

  // Resolved-branch training: saturate on hit, allocate weakly-taken on taken miss.
  always_comb begin
    upd_we     = update_btb && (u_hit || branch_outcome);
    upd_target = branch_target;
    upd_ctr    = CTR_WEAK;
    if (u_hit) begin
      if (branch_outcome) begin
        upd_ctr = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CTR_BITS'(1);
      end else begin
        upd_target = target_q[u_idx];
        upd_ctr    = (ctr_q[u_idx] == '0) ? '0 : ctr_q[u_idx] - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (upd_we) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
      ctr_q[u_idx]    <= upd_ctr;
    end
  end

endmodule
